// File: rtl/serial_ripple_subtractor.sv
// rtl/serial_ripple_subtractor.sv - bit-serial ripple-borrow subtractor, D = X - Y - Bin, LSB first
module serial_ripple_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    // Counter wide enough to index WIDTH-1; at least one bit so WIDTH=1 still elaborates.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] xs_q;
    logic [WIDTH-1:0] ys_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q;
    logic             xmsb_q;
    logic             ymsb_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             ovf_q;

    logic             di_d;
    logic             borrow_d;
    logic [WIDTH-1:0] di_msb;
    logic [WIDTH-1:0] acc_d;

    // Single full-subtractor cell on the current LSBs, plus the accumulator with the new bit at the MSB.
    always_comb begin
        di_d             = xs_q[0] ^ ys_q[0] ^ borrow_q;
        borrow_d         = (~xs_q[0] & ys_q[0]) | (~(xs_q[0] ^ ys_q[0]) & borrow_q);
        di_msb           = '0;
        di_msb[WIDTH-1]  = di_d;
        acc_d            = (acc_q >> 1) | di_msb;
    end

    // Control FSM and datapath; the partial difference lives in acc_q so d only changes when a result completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            xs_q        <= '0;
            ys_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            borrow_q    <= 1'b0;
            xmsb_q      <= 1'b0;
            ymsb_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            d_q         <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        xs_q       <= x;
                        ys_q       <= y;
                        borrow_q   <= bin;
                        cnt_q      <= '0;
                        acc_q      <= '0;
                        xmsb_q     <= x[WIDTH-1];
                        ymsb_q     <= y[WIDTH-1];
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    xs_q     <= xs_q >> 1;
                    ys_q     <= ys_q >> 1;
                    borrow_q <= borrow_d;
                    acc_q    <= acc_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        d_q         <= acc_d;
                        bout_q      <= borrow_d;
                        // Overflow only possible when operand signs differ and the result sign leaves the minuend's.
                        ovf_q       <= (xmsb_q != ymsb_q) && (acc_d[WIDTH-1] != xmsb_q);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb/tb_serial_ripple_subtractor.sv - self-checking bench for serial_ripple_subtractor
module tb_serial_ripple_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;

    int checks = 0;
    int errors = 0;
    int ops_issued = 0;
    int done_count = 0;

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    // Reference: {ovf, bout, d} from plain integer arithmetic on the operands.
    function automatic logic [5:0] ref_sub(input int xv, input int yv, input int bv);
        int diff;
        int sx;
        int sy;
        int sd;
        logic [5:0] r;
        diff = xv - yv - bv;
        sx   = (xv >= 8) ? xv - 16 : xv;
        sy   = (yv >= 8) ? yv - 16 : yv;
        sd   = sx - sy - bv;
        r[3:0] = diff[3:0];
        r[4]   = (diff < 0);
        r[5]   = (sd < -8) || (sd > 7);
        return r;
    endfunction

    // Transaction-level model: result due W edges after acceptance, held until consumed.
    logic       m_known = 1'b0;
    logic       m_rdy;
    logic       m_valid;
    logic       m_run;
    int         m_cnt;
    logic [5:0] m_pend;
    logic [5:0] m_res;

    // Compare process: check DUT against the model, then advance the model over the coming edge.
    always @(negedge clk) begin
        if (m_known) begin
            chk("in_ready",  {31'b0, in_ready},  {31'b0, m_rdy});
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            chk("d",         {28'b0, d},         {28'b0, m_res[3:0]});
            chk("bout",      {31'b0, bout},      {31'b0, m_res[4]});
            chk("ovf",       {31'b0, ovf},       {31'b0, m_res[5]});
        end
        if (rst) begin
            m_known = 1'b1;
            m_rdy   = 1'b1;
            m_valid = 1'b0;
            m_run   = 1'b0;
            m_cnt   = 0;
            m_res   = '0;
        end else if (m_known) begin
            if (m_rdy && in_valid) begin
                m_rdy  = 1'b0;
                m_run  = 1'b1;
                m_cnt  = 0;
                m_pend = ref_sub(int'(x), int'(y), int'(bin));
            end else if (m_run) begin
                m_cnt++;
                if (m_cnt == W) begin
                    m_run   = 1'b0;
                    m_valid = 1'b1;
                    m_res   = m_pend;
                    done_count++;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
                m_rdy   = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation; gap = cycles of backpressure in DONE with in_valid/x/y churning.
    task automatic do_op(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic bv, input int gap,
                         output logic [W-1:0] dv, output logic bo, output logic ov, output int lat);
        int n;
        x        = xv;
        y        = yv;
        bin      = bv;
        in_valid = 1'b1;
        n        = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) timeout_fail("accept");
        tick();
        ops_issued++;
        in_valid = 1'b0;
        x        = W'($urandom);
        y        = W'($urandom);
        bin      = 1'($urandom);
        lat      = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!out_valid) timeout_fail("result");
        dv = d;
        bo = bout;
        ov = ovf;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'($urandom);
            x        = W'($urandom);
            y        = W'($urandom);
            bin      = 1'($urandom);
            tick();
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_d_stable", {28'b0, d}, {28'b0, dv});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_after_consume", {31'b0, in_ready}, 32'd1);
    endtask

    logic [W-1:0] rd;
    logic         rb;
    logic         ro;
    int           lat;
    logic [5:0]   r;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        y         = '0;
        bin       = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        chk("reset_in_ready",  {31'b0, in_ready},  32'd1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_d",         {28'b0, d},         32'd0);
        chk("reset_bout",      {31'b0, bout},      32'd0);
        chk("reset_ovf",       {31'b0, ovf},       32'd0);

        // Pin the model against hand-computed values.
        chk("model_9_6_0",  {26'b0, ref_sub(9, 6, 0)},  {26'b0, 6'b10_0011});
        chk("model_0_1_0",  {26'b0, ref_sub(0, 1, 0)},  {26'b0, 6'b01_1111});
        chk("model_15_9_1", {26'b0, ref_sub(15, 9, 1)}, {26'b0, 6'b00_0101});
        chk("model_7_8_0",  {26'b0, ref_sub(7, 8, 0)},  {26'b0, 6'b11_1111});

        do_op(4'b1001, 4'b0110, 1'b0, 0, rd, rb, ro, lat);
        chk("t1_d", {28'b0, rd}, 32'b0011);
        chk("t1_bout", {31'b0, rb}, 32'd0);
        chk("t1_ovf", {31'b0, ro}, 32'd1);

        do_op(4'b0000, 4'b0001, 1'b0, 0, rd, rb, ro, lat);
        chk("t2_d", {28'b0, rd}, 32'b1111);
        chk("t2_bout", {31'b0, rb}, 32'd1);
        chk("t2_ovf", {31'b0, ro}, 32'd0);
        chk("t2_latency", lat, 32'd4);

        do_op(4'b1111, 4'b1001, 1'b1, 0, rd, rb, ro, lat);
        chk("t3a_d", {28'b0, rd}, 32'b0101);
        chk("t3a_bout", {31'b0, rb}, 32'd0);
        chk("t3a_ovf", {31'b0, ro}, 32'd0);
        do_op(4'b0111, 4'b1000, 1'b0, 0, rd, rb, ro, lat);
        chk("t3b_d", {28'b0, rd}, 32'b1111);
        chk("t3b_bout", {31'b0, rb}, 32'd1);
        chk("t3b_ovf", {31'b0, ro}, 32'd1);

        do_op(4'b0011, 4'b0101, 1'b0, 3, rd, rb, ro, lat);
        chk("bp_d", {28'b0, rd}, 32'b1110);
        chk("bp_bout", {31'b0, rb}, 32'd1);

        // Reset after two RUN cycles discards the operation.
        x        = 4'b1010;
        y        = 4'b0011;
        bin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_d",         {28'b0, d},         32'd0);
        chk("mid_rst_bout",      {31'b0, bout},      32'd0);
        do_op(4'b1010, 4'b1000, 1'b0, 0, rd, rb, ro, lat);
        chk("post_rst_d", {28'b0, rd}, 32'b0010);
        chk("post_rst_bout", {31'b0, rb}, 32'd0);
        chk("post_rst_ovf", {31'b0, ro}, 32'd0);

        // Exhaustive sweep with random idle gaps and backpressure.
        for (int xv = 0; xv < 16; xv++) begin
            for (int yv = 0; yv < 16; yv++) begin
                for (int bv = 0; bv < 2; bv++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    do_op(W'(xv), W'(yv), 1'(bv), int'($urandom_range(0, 3)), rd, rb, ro, lat);
                    r = ref_sub(xv, yv, bv);
                    chk("sweep_result", {26'b0, ro, rb, rd}, {26'b0, r});
                    chk("sweep_latency", lat, 32'd4);
                end
            end
        end

        tick();
        chk("op_count", done_count, ops_issued);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_ripple_subtractor.md
Name: serial_ripple_subtractor

Overview:
- Bit-serial ripple-borrow subtractor: computes D = X − Y − Bin one bit per clock, LSB first, reusing a single full-subtractor cell.
- Counterpart (inverse operation) to the team's combinational ripple-carry adder.
- Sits between an operand producer and a result consumer with valid/ready handshakes on both sides.
- Area-for-latency trade: one cell plus shift registers instead of WIDTH cells.

Parameters:
- WIDTH, 4, operand and result width in bits (legal ≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands x, y, bin valid.
- in_ready  output  1  block can accept operands (IDLE only).
- x  input  WIDTH  minuend.
- y  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- d  output  WIDTH  difference.
- bout  output  1  borrow-out (1 ⇔ x < y + bin, unsigned).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Interface clocking: single clock clk; reset rst is synchronous, active-high.
- Reset (rst=1 at an edge):
  - state=IDLE, bit counter=0, borrow reg=0.
  - d=0, bout=0, ovf=0, out_valid=0, in_ready=1 from the following cycle.
  - rst overrides all other inputs in every state, including mid-RUN; any partial result is discarded.
- FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from state only; no combinational path from in_valid/out_ready to any output.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready at edge E0: latch x→xs, y→ys, borrow←bin, cnt←0, save x[MSB] and y[MSB]; go to RUN.
- RUN:
  - in_ready=0, out_valid=0; in_valid is ignored.
  - Each edge: b = borrow, xi = xs[0], yi = ys[0].
  - Difference bit: di = xi ^ yi ^ b. Next borrow: (~xi & yi) | (~(xi ^ yi) & b).
  - Shift di into d from the MSB side (right shift), shift xs and ys right, cnt++.
  - At the edge where cnt == WIDTH−1: go to DONE, set out_valid=1, bout = final borrow.
  - ovf = (xMSB != yMSB) & (d[MSB] != xMSB).
- Latency: out_valid asserts after edge E0+WIDTH, i.e. WIDTH cycles after acceptance. WIDTH=1 gives a single RUN cycle.
- DONE:
  - out_valid=1; d, bout, ovf held stable while out_ready=0 (unbounded backpressure).
  - On out_ready=1 at an edge: out_valid←0, go to IDLE. d, bout, ovf keep their last value until the next result.
- Throughput: one operation per WIDTH+2 cycles minimum. Input and output transactions never overlap; in_valid during RUN/DONE has no effect and the producer must hold it.
- Simultaneous rst and in_valid/out_ready: rst wins.

Test Plan (WIDTH=4):
- x=1001, y=0110, bin=0 → after 4 cycles: d=0011, bout=0, ovf=1.
- x=0000, y=0001, bin=0 → d=1111, bout=1, ovf=0; out_valid rises exactly 4 cycles after the acceptance edge.
- x=1111, y=1001, bin=1 → d=0101, bout=0, ovf=0. Then x=0111, y=1000, bin=0 → d=1111, bout=1, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid and new x/y:
  - d, bout, ovf, out_valid stay stable and in_ready stays 0.
  - On the out_ready pulse, IDLE is reached the next cycle.
- Reset mid-operation: assert rst for 1 cycle after 2 RUN cycles of x=1010, y=0011 →
  - next cycle: in_ready=1, out_valid=0, d=0, bout=0.
  - A following x=1010, y=1000, bin=0 gives d=0010, bout=0, ovf=0.
- Exhaustive sweep of all x, y ∈ 0..15, bin ∈ {0,1} against a reference model (x−y−bin mod 16, borrow, signed overflow), with randomized in_valid/out_ready gaps.
